// File: rtl/fp2pcm.sv
// fp2pcm: iterative IEEE-754 single-precision to signed 16-bit Q1.15 PCM converter.
//
// The block converts a float in the range [-1.0, 1.0) to a saturated two's-complement
// PCM word. Deasserting reset starts a conversion. dataa is sampled on the first rising
// edge with reset low. The magnitude is then shifted right one bit per cycle.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous active-high; holds idle, release starts a conversion
//   dataa   in  32   float input, sampled once on the first edge with reset low
//   result  out 16   signed Q1.15 sample, registered
//   done    out  1   result valid; held until the next reset
//
// Build option:
//   FP2PCM_ROUND_EN  defined   -> round half away from zero using the guard bit
//                    undefined -> truncate toward zero (same latency)

module fp2pcm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  output logic [15:0] result,
  output logic        done
);

  typedef enum logic [2:0] {
    StLoad,
    StShift,
    StRound,
    StOutput,
    StDone
  } state_e;

  state_e      state_q;
  logic [16:0] mag_q;
  logic [4:0]  count_q;
  logic        sign_q;
  logic [15:0] result_q;
  logic        done_q;
`ifdef FP2PCM_ROUND_EN
  logic        guard_q;
`endif

  logic        sign_in;
  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic [4:0]  count_in;
  logic [15:0] pos_mag;
  logic [15:0] neg_mag;

  assign sign_in = dataa[31];
  assign exp_in  = dataa[30:23];
  assign frac_in = dataa[22:0];

  // 127 - e for 111 <= e <= 126. Over that range e - 96 == e[4:0],
  // so the shift count is 31 - e[4:0], giving 1..16.
  assign count_in = 5'd31 - exp_in[4:0];

  // A rounded magnitude can reach 32768; only the positive side saturates.
  assign pos_mag = (mag_q > 17'd32767) ? 16'h7FFF : mag_q[15:0];
  // A magnitude of 32768 negates to 0x8000, which is exactly -1.0.
  assign neg_mag = 16'd0 - mag_q[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StLoad;
      mag_q    <= 17'd0;
      count_q  <= 5'd0;
      sign_q   <= 1'b0;
      result_q <= 16'd0;
      done_q   <= 1'b0;
`ifdef FP2PCM_ROUND_EN
      guard_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (exp_in == 8'd0) begin
            // Zero or denormal.
            result_q <= 16'd0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (exp_in == 8'd255 && frac_in != 23'd0) begin
            // NaN.
            result_q <= 16'd0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (exp_in >= 8'd127) begin
            // |x| >= 1.0 or infinity: saturate. -1.0 lands exactly on 0x8000.
            result_q <= sign_in ? 16'h8000 : 16'h7FFF;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (exp_in <= 8'd110) begin
            // Below 2^-16: even the guard bit cannot reach one LSB.
            result_q <= 16'd0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            mag_q   <= {1'b0, 1'b1, dataa[22:8]};
            count_q <= count_in;
            sign_q  <= sign_in;
`ifdef FP2PCM_ROUND_EN
            guard_q <= dataa[7];
`endif
            state_q <= StShift;
          end
        end

        StShift: begin
          mag_q   <= {1'b0, mag_q[16:1]};
`ifdef FP2PCM_ROUND_EN
          guard_q <= mag_q[0];
`endif
          count_q <= count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_q <= StRound;
          end
        end

        StRound: begin
`ifdef FP2PCM_ROUND_EN
          mag_q <= mag_q + {16'd0, guard_q};
`endif
          state_q <= StOutput;
        end

        StOutput: begin
          result_q <= sign_q ? neg_mag : pos_mag;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end

        StDone: begin
          // Hold until the next reset; dataa is ignored here.
        end

        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: doc/fp2pcm.md
# fp2pcm

Iterative IEEE-754 single-precision to 16-bit signed PCM converter. It sits directly downstream of the floating-point multiplier in the voice/gain path. It takes the scaled float sample in the range [-1.0, 1.0) and produces a saturated two's-complement Q1.15 word for the audio codec interface. It uses the same reset-as-start / `done` handshake as the other DSP blocks, and shifts one bit per cycle to keep area small.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; holds the block idle, and deassertion starts a conversion
- `dataa`  in  32  float input; sampled once, on the first rising edge with `reset` low
- `result`  out  16  signed Q1.15 PCM sample, registered
- `done`  out  1  high when `result` is valid; stays high until the next `reset`

## Operation
- Reset state: `result`=0, `done`=0, FSM=LOAD, internal counter/shifter cleared.
- Edge k=1 is the first rising edge with `reset` low. Field names: s = `dataa[31]`, e = `dataa[30:23]`, m = {1,`dataa[22:0]`} (24 bits).
- LOAD (edge 1) classifies the input. Fast paths set `result`, set `done`=1, and go to DONE:
  - e==0 (zero/denormal): 0.
  - e==255, `dataa[22:0]`!=0 (NaN): 0.
  - e==255 inf, or e>=127 (|x|>=1.0): s=0 gives 0x7FFF; s=1 gives 0x8000. -1.0 exactly maps to 0x8000.
  - e<=110: 0. This holds in both rounding modes.
- LOAD otherwise (111<=e<=126):
  - Load mag = m[23:8] and guard = m[7].
  - Load count = 127-e (range 1..16), sign reg = s.
  - Go to SHIFT.
- SHIFT: each cycle, {mag,guard} shifts right by 1 (zero fill) and count decrements. When count reaches 0, go to ROUND.
- ROUND: with the rounding macro, mag = mag + guard (17-bit sum, round half away from zero). Without the macro, mag is unchanged. Go to OUTPUT.
- OUTPUT: clamp and negate, set `done`=1, go to DONE.
  - s=0: `result` = min(mag, 32767).
  - s=1: `result` = -mag. A magnitude of 32768 is representable as 0x8000.
- DONE: hold `result` and `done`. `dataa` changes are ignored.
- Arithmetic: all internal magnitudes are unsigned 17 bits. Negation is two's complement on 16 bits after the clamp.

## Timing
- Fast path: `done`=1 and `result` valid after edge 1.
- Normal path:
  - Edge 1 is LOAD.
  - Edges 2..count+1 are SHIFT.
  - Edge count+2 is ROUND.
  - Edge count+3 is OUTPUT.
  - `done` rises after edge count+3, giving a latency of 4..19 cycles.
- `done` and `result` change together on the same edge, never separately.
- `reset` asserted at any point, including mid-SHIFT, aborts the conversion. On that edge, `done`=0 and `result`=0. The next conversion samples `dataa` on the first edge with `reset` low again.
- `reset` held high for multiple cycles keeps the block idle; there is no stray `done`.
- `dataa` must be valid at edge 1 only.

## Configuration
- `FP2PCM_ROUND_EN`, when defined: the ROUND state adds guard, round-half-away-from-zero. A positive overflow to 32768 is clamped to 0x7FFF.
- When undefined: truncation toward zero and the guard bit is ignored. The ROUND state still exists, so latency is identical in both builds.

## Test plan
- 0x3F000000 (0.5) -> `result`=0x4000, `done` rises after edge 4 (count=1); `done` stays high for 10 further cycles.
- 0xBF800000 (-1.0) -> 0x8000 after edge 1. 0x40000000 (2.0) -> 0x7FFF. 0xFF800000 (-inf) -> 0x8000. 0x7FC00000 (NaN) -> 0x0000. 0x00000000 -> 0x0000.
- 0x3EAAAAAB (0.33333334):
  - -> 0x2AAB (10923) with `FP2PCM_ROUND_EN`, 0x2AAA (10922) without.
  - Sign-flipped 0xBEAAAAAB -> 0xD555 / 0xD556.
  - `done` after edge 5.
- 0x3F7FFFFF (0.99999994) -> 0x7FFF in both builds; the rounded sum of 32768 must clamp. 0x37800000 (2^-16) -> 0x0001 with rounding, 0x0000 without. 0x37000000 (2^-17, e=110) -> 0x0000.
- Start 0x3A000000 (e=116, count 11), then assert `reset` on edge 6 -> `done`=0 and `result`=0 on that edge. Release with `dataa`=0x3F000000 -> 0x4000 after 4 edges, with no residue from the aborted run.
